// File: rtl/ms_wb_pkg.sv
// Shared types for the Wishbone single-transaction initiator.
// FSM encoding and wait-counter width.
package ms_wb_pkg;

  localparam int WAIT_W = 16;

  typedef logic [WAIT_W-1:0] wait_cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

endpackage

// File: rtl/ms_wb_initiator.sv
// Wishbone classic initiator: one outstanding command,
// bounded ack wait, buffered response.
module ms_wb_initiator
  import ms_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy
);

  localparam wait_cnt_t TO_LAST = WAIT_W'(TIMEOUT - 1);

  wb_state_e state_q;
  wb_state_e state_d;

  wait_cnt_t   wait_q;
  logic        we_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic [3:0]  sel_q;
  logic [31:0] rsp_dat_q;
  logic        rsp_err_q;

  logic accept;
  logic in_bus;
  logic bus_ack;
  logic bus_to;

  assign accept  = (state_q == ST_IDLE) && cmd_valid;
  assign in_bus  = (state_q == ST_BUS);
  assign bus_ack = in_bus && wbm_ack_i;
  // Timeout fires on the TIMEOUT-th stb cycle; ack wins a tie.
  assign bus_to  = in_bus && !wbm_ack_i
                   && (wait_q == TO_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) state_d = ST_BUS;
      end
      ST_BUS: begin
        if (bus_ack || bus_to) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    wbm_cyc_o = in_bus;
    wbm_stb_o = in_bus;
    rsp_valid = (state_q == ST_RESP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_q    <= '0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (accept) begin
        we_q   <= cmd_we;
        adr_q  <= cmd_adr;
        dat_q  <= cmd_dat;
        sel_q  <= cmd_sel;
        wait_q <= '0;
      end else if (in_bus && !wbm_ack_i) begin
        wait_q <= wait_q + 1'b1;
      end
      if (bus_ack) begin
        rsp_dat_q <= we_q ? 32'h0 : wbm_dat_i;
        rsp_err_q <= 1'b0;
      end else if (bus_to) begin
        rsp_dat_q <= 32'h0;
        rsp_err_q <= 1'b1;
      end
    end
  end

  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = sel_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ms_wb_initiator.sv
// Directed bench for ms_wb_initiator with a response
// scoreboard and a programmable-latency slave.
module tb_ms_wb_initiator;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        busy;

  always #5 clk = ~clk;

  ms_wb_initiator #(.TIMEOUT(4)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i),
    .busy      (busy)
  );

  // Slave: ack when the stb run reaches ack_at (0 = same cycle).
  int          ack_at = -1;
  logic        stray_ack = 1'b0;
  logic [31:0] slave_dat = '0;
  int          stb_cnt = 0;
  int          last_len = 0;

  always_ff @(posedge clk) begin
    if (wbm_stb_o) begin
      stb_cnt <= stb_cnt + 1;
    end else begin
      if (stb_cnt != 0) last_len <= stb_cnt;
      stb_cnt <= 0;
    end
  end

  assign wbm_ack_i = (wbm_stb_o && stb_cnt == ack_at)
                     || stray_ack;
  assign wbm_dat_i = slave_dat;

  typedef struct packed {
    logic        err;
    logic [31:0] dat;
  } rsp_t;

  rsp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic send(input logic we,
                      input logic [31:0] adr,
                      input logic [31:0] dat,
                      input logic [3:0] sel);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", {31'b0, cmd_ready}, 32'd1);
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic recv(input string tag);
    int   n = 0;
    rsp_t exp;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
    if (sb.size() != 0) begin
      exp = sb.pop_front();
      check({tag, "_err"}, {31'b0, rsp_err},
            {31'b0, exp.err});
      check({tag, "_dat"}, rsp_dat, exp.dat);
    end else begin
      check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    rst_i     = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_dat   = '0;
    cmd_sel   = '0;
    rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    check("rst_stb", {31'b0, wbm_stb_o}, 32'd0);
    check("rst_we", {31'b0, wbm_we_o}, 32'd0);
    check("rst_adr", wbm_adr_o, 32'd0);
    check("rst_dat", wbm_dat_o, 32'd0);
    check("rst_sel", {28'b0, wbm_sel_o}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'd0);
    rst_i = 1'b0;

    // Write, ack on 3rd stb cycle
    ack_at    = 2;
    slave_dat = 32'hFFFF_0000;
    send(1'b1, 32'h3000_0004, 32'h1234_5678, 4'hF);
    sb.push_back('{err: 1'b0, dat: 32'h0});
    @(negedge clk);
    check("wr_stb", {31'b0, wbm_stb_o}, 32'd1);
    check("wr_cyc", {31'b0, wbm_cyc_o}, 32'd1);
    check("wr_we", {31'b0, wbm_we_o}, 32'd1);
    check("wr_adr", wbm_adr_o, 32'h3000_0004);
    check("wr_dat", wbm_dat_o, 32'h1234_5678);
    check("wr_sel", {28'b0, wbm_sel_o}, 32'hF);
    recv("wr");
    @(negedge clk);
    check("wr_len", last_len, 32'd3);

    // Read, combinational ack, 2-cycle latency
    ack_at    = 0;
    slave_dat = 32'hA5A5_A5A5;
    send(1'b0, 32'h3002_0000, 32'h0, 4'hF);
    sb.push_back('{err: 1'b0, dat: 32'hA5A5_A5A5});
    @(negedge clk);
    check("rd_stb", {31'b0, wbm_stb_o}, 32'd1);
    check("rd_we", {31'b0, wbm_we_o}, 32'd0);
    check("rd_early", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("rd_lat2", {31'b0, rsp_valid}, 32'd1);
    check("rd_stb_off", {31'b0, wbm_stb_o}, 32'd0);
    recv("rd");

    // Timeout, no ack
    ack_at    = -1;
    slave_dat = 32'hFFFF_FFFF;
    send(1'b0, 32'h3000_0100, 32'h0, 4'h3);
    sb.push_back('{err: 1'b1, dat: 32'h0});
    recv("to");
    @(negedge clk);
    check("to_len", last_len, 32'd4);

    // Ack in the same cycle the timeout would fire
    ack_at    = 3;
    slave_dat = 32'hDEAD_BEEF;
    send(1'b0, 32'h3000_0200, 32'h0, 4'hF);
    sb.push_back('{err: 1'b0, dat: 32'hDEAD_BEEF});
    recv("tie");
    @(negedge clk);
    check("tie_len", last_len, 32'd4);

    // Back-pressure with stray acks and a blocked command
    ack_at    = 1;
    slave_dat = 32'h0BAD_F00D;
    send(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    sb.push_back('{err: 1'b0, dat: 32'h0BAD_F00D});
    repeat (3) @(negedge clk);
    slave_dat = 32'h1111_1111;
    cmd_we    = 1'b1;
    cmd_adr   = 32'h3000_0FF0;
    cmd_dat   = 32'h7777_7777;
    cmd_valid = 1'b1;
    stray_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_dat", rsp_dat, 32'h0BAD_F00D);
      check("bp_err", {31'b0, rsp_err}, 32'd0);
      check("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      check("bp_stb", {31'b0, wbm_stb_o}, 32'd0);
      @(negedge clk);
    end
    check("bp_adr_held", wbm_adr_o, 32'h3000_0010);
    cmd_valid = 1'b0;
    stray_ack = 1'b0;
    recv("bp");
    @(negedge clk);
    check("bp_idle_ready", {31'b0, cmd_ready}, 32'd1);
    check("bp_idle_busy", {31'b0, busy}, 32'd0);
    check("bp_idle_stb", {31'b0, wbm_stb_o}, 32'd0);

    // Reset during 2nd BUS cycle aborts the transaction
    ack_at = -1;
    send(1'b1, 32'h3000_0020, 32'hCAFE_0001, 4'h1);
    @(negedge clk);
    check("ab_stb1", {31'b0, wbm_stb_o}, 32'd1);
    @(negedge clk);
    check("ab_stb2", {31'b0, wbm_stb_o}, 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    check("ab_stb", {31'b0, wbm_stb_o}, 32'd0);
    check("ab_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    check("ab_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("ab_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("ab_adr", wbm_adr_o, 32'd0);
    rst_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("ab_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end

    // Recovery after abort
    ack_at    = 0;
    slave_dat = 32'h5A5A_0001;
    send(1'b0, 32'h3000_0030, 32'h0, 4'hC);
    sb.push_back('{err: 1'b0, dat: 32'h5A5A_0001});
    recv("rec");

    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ms_wb_initiator.md
MS_WB_INITIATOR -- requirements
Module: ms_wb_initiator

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of wait cycles for ack, in cycles after stb assertion; legal range 1..65535.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit: the block can accept a command.
REQ-006 The block SHALL have port cmd_we, input, 1 bit: 1 = write, 0 = read.
REQ-007 The block SHALL have ports cmd_adr and cmd_dat, inputs, 32 bits each: address and write data.
REQ-008 The block SHALL have port cmd_sel, input, 4 bits: byte lanes.
REQ-009 The block SHALL have port rsp_valid, output, 1 bit: a response is available.
REQ-010 The block SHALL have port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-011 The block SHALL have port rsp_dat, output, 32 bits: read data.
REQ-012 The block SHALL have port rsp_err, output, 1 bit: the transaction timed out.
REQ-013 The block SHALL have ports wbm_cyc_o, wbm_stb_o and wbm_we_o, outputs, 1 bit each: Wishbone master controls.
REQ-014 The block SHALL have ports wbm_adr_o and wbm_dat_o, outputs, 32 bits each, and port wbm_sel_o, output, 4 bits.
REQ-015 The block SHALL have port wbm_dat_i, input, 32 bits, and port wbm_ack_i, input, 1 bit: slave read data and acknowledge.
REQ-016 The block SHALL have port busy, output, 1 bit: the state is not IDLE.

Function
REQ-017 The block SHALL implement an FSM with the states IDLE, BUS and RESP; cmd_ready SHALL equal (state == IDLE).
REQ-018 In IDLE with cmd_valid=1, the block SHALL register we/adr/dat/sel at that edge and go to BUS; wbm_cyc_o and wbm_stb_o SHALL be high from the next cycle.
REQ-019 In BUS, wbm_cyc_o and wbm_stb_o SHALL be high, and adr/dat/sel/we SHALL be held stable until the transaction ends.
REQ-020 In BUS, ack_i sampled high SHALL end the transaction: the block SHALL capture rsp_dat = wbm_dat_i for a read, or 0 for a write, set rsp_err=0, and go to RESP; cyc/stb SHALL be low in the following cycle.
REQ-021 An ack in the first BUS cycle (a combinationally acking slave) SHALL be legal; the minimum command-accept to rsp_valid latency is 2 cycles.
REQ-022 A 16-bit wait counter SHALL clear on entry to BUS and increment on each BUS cycle without ack.
REQ-023 When the wait counter reaches TIMEOUT with ack low, the block SHALL drop cyc/stb, set rsp_err=1 and rsp_dat=0, and go to RESP.
REQ-024 If ack arrives in the same cycle the counter reaches TIMEOUT, ack SHALL win (rsp_err=0).
REQ-025 In RESP, rsp_valid SHALL be 1 and rsp_dat/rsp_err SHALL be stable; rsp_valid and rsp_ready both high at an edge SHALL return the FSM to IDLE.
REQ-026 A new command SHALL NOT be accepted in the cycle the response is consumed: there is one outstanding transaction, and no command is accepted while in RESP.
REQ-027 ack_i arriving outside BUS SHALL be ignored.
REQ-028 wbm_dat_o SHALL be driven with the latched data for reads as well (don't-care for slaves).

Reset
REQ-029 rst_i high at an edge SHALL force IDLE with: cyc/stb/we=0, adr/dat=0, sel=0, counter=0, rsp_valid=0, rsp_err=0 and rsp_dat=0.
REQ-030 rst_i mid-BUS SHALL abort the cycle: cyc/stb SHALL be low the next cycle and no response SHALL be produced.
REQ-031 Reset SHALL have priority over all other events.

Structure
REQ-032 The FSM state encoding and the timeout-counter width SHALL live in shared package ms_wb_pkg.
REQ-033 The block SHALL be a single module with no sub-modules; the timeout counter stays inline.

Verification
REQ-034 Write adr=0x30000004, dat=0x12345678, sel=0xF, with slave ack on the 3rd stb cycle -> cyc/stb high for exactly 3 cycles, wbm_we_o=1, then rsp_valid=1 with rsp_err=0 and rsp_dat=0.
REQ-035 Read adr=0x30020000 with combinational ack and wbm_dat_i=0xA5A5A5A5 -> rsp_valid 2 cycles after accept, with rsp_dat=0xA5A5A5A5.
REQ-036 TIMEOUT=4 with no ack -> stb high for 4 cycles, then rsp_err=1 and rsp_dat=0.
REQ-037 TIMEOUT=4 with ack in the 4th cycle -> rsp_err=0 and the data is captured.
REQ-038 rsp_ready held low for 10 cycles -> rsp_valid and rsp_dat stable, cmd_ready=0 throughout, and a second cmd_valid is not accepted.
REQ-039 rst_i asserted during the 2nd BUS cycle -> cyc/stb low the next cycle, rsp_valid stays 0, and cmd_ready=1 after reset.
